// File: rtl/uart_frame_ctrl_if.sv
// Byte-stream input, VRAM write port and frame status of uart_frame_ctrl.
// master: frame controller side; slave: receiver/arbiter/observer side.
interface uart_frame_ctrl_if #(
    parameter int ADDR_W = 13
);
    logic [7:0]        rx_data;
    logic              rx_new;
    logic              wr_req;
    logic              wr_gnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_ok;
    logic              frame_err;
    logic              busy;

    modport master (
        input  rx_data, rx_new, wr_gnt,
        output wr_req, wr_addr, wr_data, frame_ok, frame_err, busy
    );

    modport slave (
        output rx_data, rx_new, wr_gnt,
        input  wr_req, wr_addr, wr_data, frame_ok, frame_err, busy
    );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Parses SYNC/ADDR_HI/ADDR_LO/LEN/payload[/CSUM] frames from a UART byte
// stream and writes each payload byte to VRAM through a req/gnt port.
// Ports: clk, rst (async, active-high), bus_io (uart_frame_ctrl_if.master):
//   rx_data/rx_new in, wr_req/wr_addr/wr_data out, wr_gnt in,
//   frame_ok/frame_err one-cycle status pulses, busy.
// Optional: define UART_FRAME_CSUM_EN to expect and check a trailing
// checksum byte (8-bit sum of ADDR_HI, ADDR_LO, LEN and payload).
module uart_frame_ctrl #(
    parameter int         ADDR_W       = 13,
    parameter int         TIMEOUT_CLKS = 50000,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input logic               clk,
    input logic               rst,
    uart_frame_ctrl_if.master bus_io
);

    localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

    localparam logic [2:0] S_HUNT  = 3'd0;
    localparam logic [2:0] S_AHI   = 3'd1;
    localparam logic [2:0] S_ALO   = 3'd2;
    localparam logic [2:0] S_LEN   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd6;
`ifdef UART_FRAME_CSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd5;
    localparam logic [2:0] S_POST  = S_CSUM;
`else
    localparam logic [2:0] S_POST  = S_DRAIN;
`endif

    logic [2:0]        state_q, state_d;
    logic [7:0]        ahi_q, ahi_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        idx_q, idx_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              wr_req_q, wr_req_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
`ifdef UART_FRAME_CSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              bad_q, bad_d;
`endif

    logic counting;
    logic expire;
    logic overrun;
    logic xfer;

    // Inactivity limit applies only while bytes of a frame are still due.
    assign counting = (state_q == S_AHI) || (state_q == S_ALO) ||
                      (state_q == S_LEN) || (state_q == S_DATA)
`ifdef UART_FRAME_CSUM_EN
                      || (state_q == S_CSUM)
`endif
                      ;

    // tmo_q lags the cycle count since the last byte by one, so the
    // abort pulse lands exactly TIMEOUT_CLKS cycles after that byte.
    assign expire = counting && !bus_io.rx_new &&
                    (tmo_q == TW'(TIMEOUT_CLKS - 2));

    // A byte arriving while the single holding register is still
    // waiting for its grant cannot be stored.
    assign overrun = bus_io.rx_new && wr_req_q && !bus_io.wr_gnt &&
                     ((state_q == S_DATA)
`ifdef UART_FRAME_CSUM_EN
                      || (state_q == S_CSUM)
`endif
                     );

    assign xfer = wr_req_q && bus_io.wr_gnt;

    always_comb begin
        state_d   = state_q;
        ahi_d     = ahi_q;
        base_d    = base_q;
        len_d     = len_q;
        idx_d     = idx_q;
        wr_req_d  = wr_req_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ok_d      = 1'b0;
        err_d     = 1'b0;
`ifdef UART_FRAME_CSUM_EN
        csum_d    = csum_q;
        bad_d     = bad_q;
`endif

        if (bus_io.rx_new || !counting) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (xfer) begin
            wr_req_d = 1'b0;
        end

        if (expire || overrun) begin
            err_d    = 1'b1;
            wr_req_d = 1'b0;
            state_d  = S_HUNT;
            tmo_d    = '0;
        end else begin
            case (state_q)
                S_HUNT: begin
                    if (bus_io.rx_new && bus_io.rx_data == SYNC_BYTE) begin
                        state_d = S_AHI;
`ifdef UART_FRAME_CSUM_EN
                        csum_d  = 8'd0;
                        bad_d   = 1'b0;
`endif
                    end
                end
                S_AHI: begin
                    if (bus_io.rx_new) begin
                        ahi_d   = bus_io.rx_data;
                        state_d = S_ALO;
`ifdef UART_FRAME_CSUM_EN
                        csum_d  = csum_q + bus_io.rx_data;
`endif
                    end
                end
                S_ALO: begin
                    if (bus_io.rx_new) begin
                        base_d  = ADDR_W'({ahi_q, bus_io.rx_data});
                        state_d = S_LEN;
`ifdef UART_FRAME_CSUM_EN
                        csum_d  = csum_q + bus_io.rx_data;
`endif
                    end
                end
                S_LEN: begin
                    if (bus_io.rx_new) begin
                        len_d   = bus_io.rx_data;
                        idx_d   = 8'd0;
                        state_d = (bus_io.rx_data == 8'd0) ? S_POST : S_DATA;
`ifdef UART_FRAME_CSUM_EN
                        csum_d  = csum_q + bus_io.rx_data;
`endif
                    end
                end
                S_DATA: begin
                    if (bus_io.rx_new) begin
                        // Loading overrides the fall of wr_req after a grant.
                        wr_data_d = bus_io.rx_data;
                        wr_addr_d = base_q + ADDR_W'(idx_q);
                        wr_req_d  = 1'b1;
                        idx_d     = idx_q + 8'd1;
                        if (idx_q + 8'd1 == len_q) begin
                            state_d = S_POST;
                        end
`ifdef UART_FRAME_CSUM_EN
                        csum_d    = csum_q + bus_io.rx_data;
`endif
                    end
                end
`ifdef UART_FRAME_CSUM_EN
                S_CSUM: begin
                    if (bus_io.rx_new) begin
                        bad_d   = (bus_io.rx_data != csum_q);
                        state_d = S_DRAIN;
                    end
                end
`endif
                S_DRAIN: begin
                    if (!wr_req_q) begin
                        state_d = S_HUNT;
`ifdef UART_FRAME_CSUM_EN
                        ok_d    = !bad_q;
                        err_d   = bad_q;
`else
                        ok_d    = 1'b1;
`endif
                    end
                end
                default: begin
                    state_d  = S_HUNT;
                    wr_req_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_HUNT;
            ahi_q     <= 8'd0;
            base_q    <= '0;
            len_q     <= 8'd0;
            idx_q     <= 8'd0;
            tmo_q     <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
            csum_q    <= 8'd0;
            bad_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ahi_q     <= ahi_d;
            base_q    <= base_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
`ifdef UART_FRAME_CSUM_EN
            csum_q    <= csum_d;
            bad_q     <= bad_d;
`endif
        end
    end

    assign bus_io.wr_req    = wr_req_q;
    assign bus_io.wr_addr   = wr_addr_q;
    assign bus_io.wr_data   = wr_data_q;
    assign bus_io.frame_ok  = ok_q;
    assign bus_io.frame_err = err_q;
    assign bus_io.busy      = (state_q != S_HUNT) || wr_req_q;

endmodule
